radix4_approx: RTL and testbench

//  - 32x32 unsigned approximate multiplier built on radix-4 (modified Booth) recoding of the multiplier B.
//  - Partial-product columns below APPROX_COLS are approximated: truncated in the carry-propagating sum, OR-merged into the low result bits.
//  - Registered datapath for the error-tolerant arithmetic tiles (filters, image kernels) of the approximate-compute array.

---
 rtl/radix4_approx_if.sv | 10 +
 rtl/radix4_approx.sv | 75 +++++++
 tb/tb_radix4_approx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/radix4_approx_if.sv
// radix4_approx_if: operand/product bus for radix4_approx.
interface radix4_approx_if;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic        out_valid;
    modport master (output in_valid, a, b, input p, out_valid);
    modport slave (input in_valid, a, b, output p, out_valid);
endinterface

// File: rtl/radix4_approx.sv
// radix4_approx: 32x32 radix-4 Booth approximate multiplier, low APPROX_COLS columns OR-merged.
// RADIX4_APPROX_PIPE_EN adds a register stage between row sum and final saturate/OR (latency 2).
module radix4_approx #(
    parameter int APPROX_COLS = 16
) (
    input logic            clk,
    input logic            rst_n,
    radix4_approx_if.slave bus
);
    localparam logic [63:0] LO_MASK = (64'd1 << APPROX_COLS) - 64'd1;
    logic [34:0] w_bx;
    logic [63:0] w_m [17];
    logic [16:0] w_neg;
    logic [66:0] w_h;
    logic [63:0] w_l;
    logic [66:0] w_hs;
    logic [63:0] w_ls;
    logic        w_vs;
    logic [63:0] r_p;
    logic        r_valid;
    assign w_bx = {2'b00, bus.b, 1'b0};
    // Digits 000/111 yield zero magnitude, so the top bit alone decides the row sign.
    for (genvar j = 0; j < 17; j++) begin : g_row
        logic [2:0] w_t;
        assign w_t = w_bx[2*j+2 -: 3];
        assign w_neg[j] = w_t[2];
        assign w_m[j] = ((w_t == 3'b011 || w_t == 3'b100) ? {31'd0, bus.a, 1'b0} :
                         (^w_t[1:0]) ? {32'd0, bus.a} : 64'd0) << (2 * j);
    end
    always_comb begin
        w_h = '0;
        w_l = '0;
        for (int j = 0; j < 17; j++) begin
            w_h = w_neg[j] ? w_h - {3'b000, w_m[j] & ~LO_MASK} : w_h + {3'b000, w_m[j] & ~LO_MASK};
            w_l = w_neg[j] ? w_l : w_l | (w_m[j] & LO_MASK);
        end
    end
`ifdef RADIX4_APPROX_PIPE_EN
    logic [66:0] r_h;
    logic [63:0] r_l;
    logic        r_v1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h  <= '0;
            r_l  <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_h <= w_h;
                r_l <= w_l;
            end
        end
    end
    assign w_hs = r_h;
    assign w_ls = r_l;
    assign w_vs = r_v1;
`else
    assign w_hs = w_h;
    assign w_ls = w_l;
    assign w_vs = bus.in_valid;
`endif
    // H never exceeds 2^64-1, so any set bit above 63 means H went negative.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_vs;
            if (w_vs) r_p <= (w_hs[66:64] != 3'b000) ? 64'd0 : (w_hs[63:0] | w_ls);
        end
    end
    assign bus.p         = r_p;
    assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_radix4_approx.sv
// tb_radix4_approx: scoreboard bench driving a K=16 and an exact (K=0) instance with identical stimulus.
module tb_radix4_approx;
`ifdef RADIX4_APPROX_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    typedef struct {
        logic [63:0] p;
        int          cyc;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [63:0] last [2];
    exp_t        q0[$];
    exp_t        q1[$];
    radix4_approx_if if16();
    radix4_approx_if if0();
    radix4_approx #(.APPROX_COLS(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    radix4_approx #(.APPROX_COLS(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input int k);
        logic signed [99:0] h = 0;
        logic [63:0] l = 0;
        logic [63:0] m;
        logic [63:0] lo;
        logic [34:0] bx;
        int d;
        lo = (64'd1 << k) - 64'd1;
        bx = {2'b00, b, 1'b0};
        for (int j = 0; j < 17; j++) begin
            d = int'(bx[2*j+1]) + int'(bx[2*j]) - 2 * int'(bx[2*j+2]);
            m = 64'((d < 0) ? -d : d) * 64'(a) << (2 * j);
            if (d > 0) begin
                h = h + 100'(m & ~lo);
                l = l | (m & lo);
            end else if (d < 0) begin
                h = h - 100'(m & ~lo);
            end
        end
        return (h < 0) ? 64'd0 : (h[63:0] | l);
    endfunction
    function automatic logic [31:0] rnd_op();
        int r;
        r = $urandom_range(0, 2);
        if (r == 0) return 32'($urandom_range(0, 199));
        if (r == 1) return $urandom & 32'h000F_FFFF;
        return $urandom;
    endfunction
    task automatic check(input string name, input logic ok, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask
    task automatic mon(input int k, input logic v, input logic [63:0] p);
        exp_t  e;
        string nm;
        nm = (k == 0) ? "K16" : "K0";
        if (!rst_n) begin
            check({nm, " reset p/out_valid"}, !v && p == 64'd0, p | 64'(v), 64'd0);
            last[k] = 64'd0;
        end else if (v) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                check({nm, " unexpected out_valid"}, 1'b0, p, 64'd0);
            end else begin
                if (k == 0) e = q0.pop_front();
                else e = q1.pop_front();
                check($sformatf("%s product (due cycle %0d)", nm, e.cyc), p == e.p && cyc == e.cyc, p, e.p);
            end
            last[k] = p;
        end else begin
            check({nm, " hold p"}, p == last[k], p, last[k]);
        end
    endtask
    always @(negedge clk) begin
        mon(0, if16.out_valid, if16.p);
        mon(1, if0.out_valid, if0.p);
    end
    task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b);
        if16.in_valid = v;
        if16.a        = a;
        if16.b        = b;
        if0.in_valid  = v;
        if0.a         = a;
        if0.b         = b;
    endtask
    // x16/x0 are constants from the specification when f16/f0 is set; otherwise the model decides.
    task automatic send(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] x16, input logic [63:0] x0, input logic f16, input logic f0);
        exp_t e;
        @(negedge clk);
        set_in(v, a, b);
        if (v) begin
            e.cyc = cyc + LAT;
            e.p   = f16 ? x16 : model(a, b, 16);
            q0.push_back(e);
            e.p   = f0 ? x0 : model(a, b, 0);
            q1.push_back(e);
        end
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, $urandom, $urandom, 64'd0, 64'd0, 1'b0, 1'b0);
    endtask
    task automatic hold_reset(input int n);
        q0.delete();
        q1.delete();
        set_in(1'b1, 32'd5, 32'd7);
        repeat (n) @(posedge clk);
        set_in(1'b0, 32'd5, 32'd7);
        #2 rst_n = 1'b1;
    endtask
    initial begin
        last[0] = 64'd0;
        last[1] = 64'd0;
        hold_reset(4);
        idle(3);
        send(1'b1, 32'd65536, 32'd3, 64'd196608, 64'd196608, 1'b1, 1'b1);
        send(1'b1, 32'd1, 32'd1, 64'd1, 64'd1, 1'b1, 1'b1);
        send(1'b1, 32'd0, 32'hFFFF_FFFF, 64'd0, 64'd0, 1'b1, 1'b1);
        send(1'b1, 32'd3, 32'd3, 64'd12, 64'd9, 1'b1, 1'b1);
        send(1'b1, 32'd100, 32'd7, 64'd800, 64'd700, 1'b1, 1'b1);
        send(1'b1, 32'd65636, 32'd150, 64'd0, 64'd9845400, 1'b0, 1'b1);
        send(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1);
        idle(2);
        send(1'b1, 32'd1, 32'd1, 64'd1, 64'd1, 1'b1, 1'b1);
        send(1'b1, 32'd2, 32'd3, 64'd0, 64'd6, 1'b0, 1'b1);
        send(1'b1, 32'd65536, 32'd3, 64'd196608, 64'd196608, 1'b1, 1'b1);
        send(1'b1, 32'd0, 32'd9, 64'd0, 64'd0, 1'b1, 1'b1);
        idle(3);
        for (int i = 0; i < 3; i++) send(1'b1, rnd_op(), rnd_op(), 64'd0, 64'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        hold_reset(3);
        idle(4);
        void'($urandom(7));
        for (int i = 0; i < 3000; i++)
            send($urandom_range(0, 9) != 0, rnd_op(), rnd_op(), 64'd0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10 && (q0.size() != 0 || q1.size() != 0); i++) idle(1);
        if (q0.size() != 0 || q1.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d/%0d products never presented, required 0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
